// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared forwarding-select encodings and shadow slot record
package hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       is_load;
    } slot_t;

endpackage

// File: rtl/hazard_cmp.sv
// rtl/hazard_cmp.sv - matches one shadow slot against one ID source register
module hazard_cmp
    import hazard_pkg::*;
(
    input  slot_t      slot,
    input  logic [4:0] rs,
    input  logic       use_rs,
    output logic       match
);

    // is_load is judged by the caller; only the destination matters here
    logic unused_is_load;
    assign unused_is_load = slot.is_load;

    // x0 is never a producer, even if a slot somehow carried it
    assign match = slot.valid && (slot.rd == rs) && (slot.rd != 5'd0) && use_rs;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - five-stage pipeline hazard, forwarding and flush control
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter bit FWD_EN = 1'b1,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_we,
    input  logic             id_is_load,
    input  logic             ex_branch_taken,
    input  logic             freeze,
    output logic             stall_if_id,
    output logic             bubble_id_ex,
    output logic             flush_if_id,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             id_byp_a,
    output logic             id_byp_b,
    output logic [CNT_W-1:0] stall_cnt
);

    slot_t ex_q, mem_q, wb_q;

    logic ex_m_a, ex_m_b, mem_m_a, mem_m_b, wb_m_a, wb_m_b;

    hazard_cmp u_cmp_ex_a  (.slot(ex_q),  .rs(id_rs1), .use_rs(id_use_rs1), .match(ex_m_a));
    hazard_cmp u_cmp_ex_b  (.slot(ex_q),  .rs(id_rs2), .use_rs(id_use_rs2), .match(ex_m_b));
    hazard_cmp u_cmp_mem_a (.slot(mem_q), .rs(id_rs1), .use_rs(id_use_rs1), .match(mem_m_a));
    hazard_cmp u_cmp_mem_b (.slot(mem_q), .rs(id_rs2), .use_rs(id_use_rs2), .match(mem_m_b));
    hazard_cmp u_cmp_wb_a  (.slot(wb_q),  .rs(id_rs1), .use_rs(id_use_rs1), .match(wb_m_a));
    hazard_cmp u_cmp_wb_b  (.slot(wb_q),  .rs(id_rs2), .use_rs(id_use_rs2), .match(wb_m_b));

    logic       load_use;
    logic       raw_any;
    logic       hazard;
    logic       do_flush;
    logic       do_stall;
    logic [1:0] fwd_a_nxt;
    logic [1:0] fwd_b_nxt;
    slot_t      id_slot;

    always_comb begin
        load_use  = (ex_m_a || ex_m_b) && ex_q.is_load;
        raw_any   = ex_m_a || ex_m_b || mem_m_a || mem_m_b || wb_m_a || wb_m_b;
        hazard    = FWD_EN ? load_use : raw_any;

        // freeze dominates; a branch flush squashes the ID instruction, so any
        // hazard it had is moot and must not be counted as a stall
        do_flush  = ex_branch_taken && !freeze;
        do_stall  = hazard && !freeze && !ex_branch_taken;

        stall_if_id  = freeze || do_stall;
        bubble_id_ex = do_flush || do_stall;
        flush_if_id  = do_flush;

        // regfile is not write-through, so a same-cycle WB write is bypassed
        id_byp_a = FWD_EN && wb_m_a && !stall_if_id && !flush_if_id;
        id_byp_b = FWD_EN && wb_m_b && !stall_if_id && !flush_if_id;

        // youngest producer (EX) wins over MEM
        fwd_a_nxt = FWD_RF;
        fwd_b_nxt = FWD_RF;
        if (FWD_EN) begin
            if (ex_m_a)       fwd_a_nxt = FWD_MEM;
            else if (mem_m_a) fwd_a_nxt = FWD_WB;
            if (ex_m_b)       fwd_b_nxt = FWD_MEM;
            else if (mem_m_b) fwd_b_nxt = FWD_WB;
        end

        id_slot.valid   = id_we && (id_rd != 5'd0);
        id_slot.rd      = id_rd;
        id_slot.is_load = id_is_load;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q      <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
            fwd_a     <= FWD_RF;
            fwd_b     <= FWD_RF;
            stall_cnt <= '0;
        end else if (freeze) begin
            ex_q      <= ex_q;
            mem_q     <= mem_q;
            wb_q      <= wb_q;
            fwd_a     <= fwd_a;
            fwd_b     <= fwd_b;
            stall_cnt <= stall_cnt;
        end else if (do_flush || do_stall) begin
            ex_q      <= '0;
            mem_q     <= ex_q;
            wb_q      <= mem_q;
            fwd_a     <= FWD_RF;
            fwd_b     <= FWD_RF;
            if (do_stall) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end else begin
            ex_q      <= id_slot;
            mem_q     <= ex_q;
            wb_q      <= mem_q;
            fwd_a     <= fwd_a_nxt;
            fwd_b     <= fwd_b_nxt;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl with and without forwarding
module tb_hazard_ctrl;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       we;
        logic       ld;
    } ins_t;

    typedef struct packed {
        logic        stall;
        logic        bubble;
        logic        flush;
        logic        byp_a;
        logic        byp_b;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [31:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic       id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, id_we = 1'b0, id_is_load = 1'b0;
    logic       ex_branch_taken = 1'b0, freeze = 1'b0;

    logic        st1, bu1, fl1, ba1, bb1, st0, bu0, fl0, ba0, bb0;
    logic [1:0]  fa1, fb1, fa0, fb0;
    logic [31:0] cnt1, cnt0;

    hazard_ctrl #(.FWD_EN(1'b1), .CNT_W(32)) dut_fwd (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_we(id_we), .id_is_load(id_is_load),
        .ex_branch_taken(ex_branch_taken), .freeze(freeze),
        .stall_if_id(st1), .bubble_id_ex(bu1), .flush_if_id(fl1),
        .fwd_a(fa1), .fwd_b(fb1), .id_byp_a(ba1), .id_byp_b(bb1), .stall_cnt(cnt1)
    );

    hazard_ctrl #(.FWD_EN(1'b0), .CNT_W(32)) dut_nofwd (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_we(id_we), .id_is_load(id_is_load),
        .ex_branch_taken(ex_branch_taken), .freeze(freeze),
        .stall_if_id(st0), .bubble_id_ex(bu0), .flush_if_id(fl0),
        .fwd_a(fa0), .fwd_b(fb0), .id_byp_a(ba0), .id_byp_b(bb0), .stall_cnt(cnt0)
    );

    bit    sel_fwd = 1'b1;
    string scen = "init";
    int    n_chk = 0;
    int    n_pass = 0;
    exp_t  q[$];
    exp_t  mon_e;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s/%s: observed %0d expected %0d", scen, tag, obs, exp_v);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            chk("stall_if_id",  32'(sel_fwd ? st1  : st0),  32'(mon_e.stall));
            chk("bubble_id_ex", 32'(sel_fwd ? bu1  : bu0),  32'(mon_e.bubble));
            chk("flush_if_id",  32'(sel_fwd ? fl1  : fl0),  32'(mon_e.flush));
            chk("id_byp_a",     32'(sel_fwd ? ba1  : ba0),  32'(mon_e.byp_a));
            chk("id_byp_b",     32'(sel_fwd ? bb1  : bb0),  32'(mon_e.byp_b));
            chk("fwd_a",        32'(sel_fwd ? fa1  : fa0),  32'(mon_e.fa));
            chk("fwd_b",        32'(sel_fwd ? fb1  : fb0),  32'(mon_e.fb));
            chk("stall_cnt",    sel_fwd ? cnt1 : cnt0,      mon_e.cnt);
        end
    end

    function automatic ins_t i_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        ins_t r;
        r = '0;
        r.rs1 = rs1; r.rs2 = rs2; r.u1 = 1'b1; r.u2 = 1'b1; r.rd = rd; r.we = 1'b1;
        return r;
    endfunction

    function automatic ins_t i_lw(input logic [4:0] rd);
        ins_t r;
        r = '0;
        r.u1 = 1'b1; r.rd = rd; r.we = 1'b1; r.ld = 1'b1;
        return r;
    endfunction

    function automatic ins_t i_nop();
        ins_t r;
        r = '0;
        return r;
    endfunction

    function automatic exp_t x(input logic s, input logic b, input logic f, input logic pa,
                               input logic pb, input logic [1:0] fa, input logic [1:0] fb,
                               input logic [31:0] c);
        exp_t r;
        r = {s, b, f, pa, pb, fa, fb, c};
        return r;
    endfunction

    task automatic drive(input ins_t in, input logic br, input logic frz, input logic r, input exp_t e);
        @(posedge clk);
        #1;
        rst             = r;
        id_rs1          = in.rs1;
        id_rs2          = in.rs2;
        id_use_rs1      = in.u1;
        id_use_rs2      = in.u2;
        id_rd           = in.rd;
        id_we           = in.we;
        id_is_load      = in.ld;
        ex_branch_taken = br;
        freeze          = frz;
        q.push_back(e);
    endtask

    task automatic step(input ins_t in, input exp_t e);
        drive(in, 1'b0, 1'b0, 1'b0, e);
    endtask

    task automatic do_reset(input bit fe, input string name);
        @(posedge clk);
        #1;
        rst = 1'b1;
        id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_we = 1'b0; id_is_load = 1'b0;
        ex_branch_taken = 1'b0; freeze = 1'b0;
        sel_fwd = fe;
        scen = name;
    endtask

    initial begin
        // add chain with forwarding, plus WB bypass and EX->rs2 forwarding
        do_reset(1'b1, "chain_fwd");
        step(i_add(1, 1, 2), x(0, 0, 0, 0, 0, 0, 0, 0));
        step(i_add(1, 1, 3), x(0, 0, 0, 0, 0, 0, 0, 0));
        step(i_add(1, 1, 4), x(0, 0, 0, 0, 0, 1, 0, 0));
        step(i_add(5, 1, 0), x(0, 0, 0, 1, 0, 1, 0, 0));
        step(i_add(6, 0, 5), x(0, 0, 0, 0, 0, 1, 0, 0));
        step(i_nop(),        x(0, 0, 0, 0, 0, 0, 1, 0));
        step(i_nop(),        x(0, 0, 0, 0, 0, 0, 0, 0));

        // same chain resolved purely by stalling: three stalls per dependency
        do_reset(1'b0, "chain_nofwd");
        step(i_add(1, 1, 2), x(0, 0, 0, 0, 0, 0, 0, 0));
        step(i_add(1, 1, 3), x(1, 1, 0, 0, 0, 0, 0, 0));
        step(i_add(1, 1, 3), x(1, 1, 0, 0, 0, 0, 0, 1));
        step(i_add(1, 1, 3), x(1, 1, 0, 0, 0, 0, 0, 2));
        step(i_add(1, 1, 3), x(0, 0, 0, 0, 0, 0, 0, 3));
        step(i_add(1, 1, 4), x(1, 1, 0, 0, 0, 0, 0, 3));
        step(i_add(1, 1, 4), x(1, 1, 0, 0, 0, 0, 0, 4));
        step(i_add(1, 1, 4), x(1, 1, 0, 0, 0, 0, 0, 5));
        step(i_add(1, 1, 4), x(0, 0, 0, 0, 0, 0, 0, 6));
        step(i_nop(),        x(0, 0, 0, 0, 0, 0, 0, 6));

        // load-use: one stall, then MEM/WB forwarding on both operands
        do_reset(1'b1, "load_use");
        step(i_lw(1),        x(0, 0, 0, 0, 0, 0, 0, 0));
        step(i_add(2, 1, 1), x(1, 1, 0, 0, 0, 0, 0, 0));
        step(i_add(2, 1, 1), x(0, 0, 0, 0, 0, 0, 0, 1));
        step(i_nop(),        x(0, 0, 0, 0, 0, 2, 2, 1));
        step(i_nop(),        x(0, 0, 0, 0, 0, 0, 0, 1));

        // x0 writers (including a load to x0) never create hazards, either mode
        for (int m = 0; m < 2; m++) begin
            do_reset(m == 0, "x0");
            step(i_add(0, 1, 2), x(0, 0, 0, 0, 0, 0, 0, 0));
            step(i_lw(0),        x(0, 0, 0, 0, 0, 0, 0, 0));
            step(i_add(3, 0, 0), x(0, 0, 0, 0, 0, 0, 0, 0));
            step(i_add(4, 0, 0), x(0, 0, 0, 0, 0, 0, 0, 0));
            step(i_nop(),        x(0, 0, 0, 0, 0, 0, 0, 0));
        end

        // taken branch together with a pending load-use is a flush only
        do_reset(1'b1, "flush_vs_load_use");
        step(i_lw(1),                             x(0, 0, 0, 0, 0, 0, 0, 0));
        drive(i_add(2, 1, 1), 1'b1, 1'b0, 1'b0,   x(0, 1, 1, 0, 0, 0, 0, 0));
        step(i_nop(),                             x(0, 0, 0, 0, 0, 0, 0, 0));
        step(i_nop(),                             x(0, 0, 0, 0, 0, 0, 0, 0));

        // freeze for 4 cycles mid-chain, including one with a branch raised
        do_reset(1'b1, "freeze");
        step(i_add(1, 1, 2), x(0, 0, 0, 0, 0, 0, 0, 0));
        step(i_add(1, 1, 3), x(0, 0, 0, 0, 0, 0, 0, 0));
        drive(i_add(1, 1, 4), 1'b0, 1'b1, 1'b0, x(1, 0, 0, 0, 0, 1, 0, 0));
        drive(i_add(1, 1, 4), 1'b0, 1'b1, 1'b0, x(1, 0, 0, 0, 0, 1, 0, 0));
        drive(i_add(1, 1, 4), 1'b1, 1'b1, 1'b0, x(1, 0, 0, 0, 0, 1, 0, 0));
        drive(i_add(1, 1, 4), 1'b0, 1'b1, 1'b0, x(1, 0, 0, 0, 0, 1, 0, 0));
        step(i_add(1, 1, 4), x(0, 0, 0, 0, 0, 1, 0, 0));
        step(i_add(7, 1, 0), x(0, 0, 0, 1, 0, 1, 0, 0));
        step(i_nop(),        x(0, 0, 0, 0, 0, 1, 0, 0));
        step(i_nop(),        x(0, 0, 0, 0, 0, 0, 0, 0));

        // reset in the middle of a stall clears slots and counter at that edge
        do_reset(1'b0, "reset_mid_stall");
        step(i_add(1, 1, 2),                      x(0, 0, 0, 0, 0, 0, 0, 0));
        step(i_add(1, 1, 3),                      x(1, 1, 0, 0, 0, 0, 0, 0));
        drive(i_add(1, 1, 3), 1'b0, 1'b0, 1'b1,   x(1, 1, 0, 0, 0, 0, 0, 1));
        step(i_add(1, 1, 3),                      x(0, 0, 0, 0, 0, 0, 0, 0));
        step(i_nop(),                             x(0, 0, 0, 0, 0, 0, 0, 0));

        // WB bypass is suppressed while a load-use stall is active
        do_reset(1'b1, "byp_gated");
        step(i_add(1, 0, 0), x(0, 0, 0, 0, 0, 0, 0, 0));
        step(i_nop(),        x(0, 0, 0, 0, 0, 0, 0, 0));
        step(i_lw(2),        x(0, 0, 0, 0, 0, 0, 0, 0));
        step(i_add(3, 1, 2), x(1, 1, 0, 0, 0, 0, 0, 0));
        step(i_add(3, 1, 2), x(0, 0, 0, 0, 0, 0, 0, 1));
        step(i_nop(),        x(0, 0, 0, 0, 0, 0, 2, 1));

        @(posedge clk);
        @(negedge clk);
        #1;
        scen = "end";
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage RV32I core (IF/ID/EX/MEM/WB). It tracks destination registers of in-flight instructions in a three-slot shadow pipeline (EX, MEM, WB) and compares them against the source registers of the instruction in ID. From that it drives forwarding selects, load-use stalls, bubbles and branch flushes. It sits beside the control unit and steers the datapath's pipeline registers and operand muxes; it owns no data values.

## Interface
- `FWD_EN`, default 1: 1 = forwarding enabled; 0 = resolve every RAW hazard by stalling.
- `CNT_W`, default 32: width of the stall-cycle counter.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `id_rs1`, `id_rs2`  in  5 each  source register indices of the ID instruction.
- `id_use_rs1`, `id_use_rs2`  in  1 each  ID instruction actually reads that source.
- `id_rd`  in  5  destination register of the ID instruction.
- `id_we`  in  1  ID instruction writes `id_rd`.
- `id_is_load`  in  1  ID instruction is a load.
- `ex_branch_taken`  in  1  EX resolved a taken branch or jump this cycle.
- `freeze`  in  1  external hold (memory busy); the whole pipeline holds.
- `stall_if_id`  out  1  hold PC and the IF/ID register.
- `bubble_id_ex`  out  1  load a NOP into ID/EX.
- `flush_if_id`  out  1  load a NOP into IF/ID.
- `fwd_a`, `fwd_b`  out  2 each  registered EX operand selects: 0 = regfile/ID/EX value, 1 = EX/MEM ALU result, 2 = MEM/WB write-back value.
- `id_byp_a`, `id_byp_b`  out  1 each  combinational; the ID read takes the WB write data (the regfile is not write-through).
- `stall_cnt`  out  `CNT_W`  number of cycles with `stall_if_id` high caused by hazards; excludes freeze.

## Operation
- Shadow slots EX, MEM and WB each hold {valid, rd, is_load}. A slot matches source `s` when valid, `rd == s`, `rd != 0`, and the source use bit is set.
- Priority per cycle: `rst` > `freeze` > flush > hazard stall > normal advance.
- Freeze: all slots, `fwd_*` and `stall_cnt` hold. `stall_if_id=1`, `bubble_id_ex=0`, `flush_if_id=0`.
- Flush (`ex_branch_taken=1`, no freeze):
  - `flush_if_id=1`, `bubble_id_ex=1`.
  - The EX slot loads invalid; MEM ← EX and WB ← MEM.
  - `fwd_*` ← 0. `stall_if_id=0`.
- Hazard stall condition:
  - `FWD_EN=1`: the EX slot matches with `is_load=1` (load-use).
  - `FWD_EN=0`: any of the EX, MEM or WB slots matches.
- Hazard stall action: `stall_if_id=1`, `bubble_id_ex=1`. The EX slot loads invalid; the others shift. `fwd_*` ← 0. `stall_cnt` increments, wrapping at 2^CNT_W.
- Normal advance: EX ← {id_we & (id_rd≠0), id_rd, id_is_load}; MEM ← EX; WB ← MEM.
  - With `FWD_EN=1`, `fwd_a` ← 1 if EX matches rs1, else 2 if MEM matches rs1, else 0. `fwd_b` follows the same rule for rs2.
  - The EX match has priority over the MEM match (youngest producer wins).
  - With `FWD_EN=0`, `fwd_*` ← 0.
- `id_byp_a/b` = WB slot matches rs1/rs2 and `FWD_EN=1`, gated to 0 during a stall or flush.
- x0 never creates a hazard and is never tracked as valid.

## Timing
- On reset:
  - All slots invalid.
  - `fwd_a=fwd_b=0`, `stall_cnt=0`.
  - `stall_if_id`, `bubble_id_ex`, `flush_if_id`, `id_byp_*` all 0 (no valid slots).
- `stall_if_id`, `bubble_id_ex`, `flush_if_id` and `id_byp_*` are combinational from the current slots and ID inputs. The datapath acts on them at the next edge.
- `fwd_*` is registered and valid during the cycle the instruction occupies EX.
- A load-use pair costs exactly one stall cycle; the second cycle then forwards with `fwd=2`.
- With `FWD_EN=0`, a back-to-back dependency costs three stall cycles.
- A flush asserted in the same cycle as a load-use condition is a flush only; `stall_cnt` does not increment.
- A reset asserted mid-stall clears everything at that edge. The first post-reset cycle shows no hazard.

## Structure
- A shared package `hazard_pkg` holds:
  - the forwarding-select encodings (`FWD_RF=0`, `FWD_MEM=1`, `FWD_WB=2`);
  - the slot record type {valid, rd[4:0], is_load}.
- One sub-module, `hazard_cmp`: compares a slot against (rs, use) and returns match. It is instantiated per slot and source (6 instances).

## Test plan
- Chain `add x1,x1,x2`; `add x1,x1,x3`; `add x1,x1,x4` with x1..x4 = 1..4 and `FWD_EN=1`:
  - no stalls;
  - the 2nd and 3rd adds see `fwd_a=1`;
  - x1 = 10, PC reaches 36 in 9 cycles after reset, `stall_cnt=0`.
- The same chain with `FWD_EN=0`:
  - `stall_if_id` high for 3 cycles before each dependent add;
  - `stall_cnt=6`, x1 = 10.
- `lw x1,0(x0)`; `add x2,x1,x1`:
  - exactly one cycle with `stall_if_id=bubble_id_ex=1`;
  - then `fwd_a=fwd_b=2`, `stall_cnt=1`.
- `add x0,x1,x2`; `add x3,x0,x0`: no stall, `fwd_a=fwd_b=0`.
- Taken branch in EX while a load-use is pending in ID:
  - `flush_if_id=1`, `bubble_id_ex=1`, `stall_if_id=0`;
  - `stall_cnt` unchanged.
- `freeze` held 4 cycles in the middle of the add chain: slots and `fwd_*` unchanged throughout; final x1 = 10 with no extra `stall_cnt`.
